// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared operation encodings, state enum and small helpers
//                for the multiply/divide unit. The divider is built only
//                when MULDIV_DIV_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SIGN = 2'd2
  } state_t;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  // Divide ops have bit 1 set.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  // Signed ops (MULT, DIV) have bit 0 clear.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_step
//  Description : One combinational iteration of the multiply/divide engine.
//                acc layout (2*WIDTH+1 bits):
//                  multiply : {0, partial[WIDTH], product bits shifted in}
//                  divide   : {remainder[WIDTH+1], quotient[WIDTH]}
//                The divide path exists only with MULDIV_DIV_EN defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0] acc,
  input  logic [WIDTH-1:0] operand,
  input  logic             in_bit,
  input  logic             div_mode,
  output logic [2*WIDTH:0] acc_next,
  output logic             q_bit
);

  logic [WIDTH:0] sum;
  logic           unused_step;

  // The top remainder bit is always zero (remainder < divisor), so the
  // shifted remainder drops it; in multiply mode it is never set.
  assign unused_step = acc[2*WIDTH];

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;

  // Shift-add for multiply, trial-subtract/restore for divide
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (in_bit ? operand : {WIDTH{1'b0}})};
    rem_sh   = {acc[2*WIDTH-1:WIDTH], in_bit};
    trial    = {1'b0, rem_sh} - {2'b00, operand};
    q_bit    = 1'b0;
    acc_next = {1'b0, sum, acc[WIDTH-1:1]};
    if (div_mode) begin
      q_bit    = ~trial[WIDTH+1];
      acc_next = {(q_bit ? trial[WIDTH:0] : rem_sh), acc[WIDTH-2:0], q_bit};
    end
  end
`else
  logic unused_mode;
  assign unused_mode = div_mode;

  // Shift-add multiply only; the divider is not built
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (in_bit ? operand : {WIDTH{1'b0}})};
    acc_next = {1'b0, sum, acc[WIDTH-1:1]};
    q_bit    = 1'b0;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative multiply/divide unit owning the HI/LO pair.
//                MULT/MULTU/DIV/DIVU complete WIDTH+1 cycles after start;
//                MTHI/MTLO write HI/LO while idle. Define MULDIV_DIV_EN to
//                build the divider; without it DIV/DIVU finish two cycles
//                after start and leave HI/LO untouched.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_next;
  logic             div_q;       // latched op is a divide
  logic             sign_a;      // signed op and a negative
  logic             sign_b;      // signed op and b negative
  logic             hold;        // extra SIGN cycle for a divide with no divider
  logic [WIDTH-1:0] operand;     // multiplicand |a| or divisor |b|
  logic [WIDTH-1:0] feed;        // multiplier |b| (LSB first) or dividend |a| (MSB first)
  logic [2*WIDTH:0] acc;
  logic [CW-1:0]    count;

  logic             in_sa, in_sb;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [2*WIDTH:0] acc_next;
  logic             q_bit;
  logic             in_bit;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic             unused_top;

  assign unused_top = q_bit;

`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0] a_orig;
  logic             b_zero;
  logic [WIDTH-1:0] quo, rem;
`endif

  // Operand magnitudes for signed ops
  always_comb begin
    in_sa = op_is_signed(op) & a[WIDTH-1];
    in_sb = op_is_signed(op) & b[WIDTH-1];
    a_abs = in_sa ? -a : a;
    b_abs = in_sb ? -b : b;
    in_bit = div_q ? feed[WIDTH-1] : feed[0];
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (operand),
    .in_bit   (in_bit),
    .div_mode (div_q),
    .acc_next (acc_next),
    .q_bit    (q_bit)
  );

  // Sign correction and special cases for the final HI/LO values
  always_comb begin
    prod = acc[2*WIDTH-1:0];
    if (sign_a ^ sign_b) prod = -prod;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    quo = acc[WIDTH-1:0];
    rem = acc[2*WIDTH-1:WIDTH];
    if (div_q) begin
      if (b_zero) begin
        res_hi = a_orig;
        res_lo = {WIDTH{1'b1}};
      end else begin
        res_lo = (sign_a ^ sign_b) ? -quo : quo;
        res_hi = sign_a ? -rem : rem;
      end
    end
`endif
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (op_is_div(op) && !DIV_EN) ? SIGN : RUN;
      RUN:  if (count == CW'(WIDTH - 1)) state_next = SIGN;
      SIGN: state_next = hold ? SIGN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status output decoded from the state register
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath: capture, iterate, write back HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
      div_q   <= 1'b0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      hold    <= 1'b0;
      operand <= '0;
      feed    <= '0;
      acc     <= '0;
      count   <= '0;
`ifdef MULDIV_DIV_EN
      a_orig  <= '0;
      b_zero  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wd;
          if (lo_we) lo <= wd;
          if (start) begin
            div_q   <= op_is_div(op);
            sign_a  <= in_sa;
            sign_b  <= in_sb;
            hold    <= op_is_div(op) & ~DIV_EN;
            operand <= op_is_div(op) ? b_abs : a_abs;
            feed    <= op_is_div(op) ? a_abs : b_abs;
            acc     <= '0;
            count   <= '0;
`ifdef MULDIV_DIV_EN
            a_orig  <= a;
            b_zero  <= (b == '0);
`endif
          end
        end
        RUN: begin
          acc   <= acc_next;
          count <= count + CW'(1);
          feed  <= div_q ? {feed[WIDTH-2:0], 1'b0} : {1'b0, feed[WIDTH-1:1]};
        end
        SIGN: begin
          if (hold) begin
            hold <= 1'b0;
          end else begin
            done <= 1'b1;
            if (!div_q || DIV_EN) begin
              hi <= res_hi;
              lo <= res_lo;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Self-checking bench for muldiv_unit (WIDTH=32) with a
//                plain-arithmetic reference model of HI/LO.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

`ifdef MULDIV_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, wd = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result {hi, lo} from integer arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin q = sx * sy; return q; end
      2'b01: begin u = {32'h0, x} * {32'h0, y}; return u; end
      2'b10: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Issue one op and follow it to its done pulse; returns in the done cycle.
  // inject: 0 none, 1 hi_we during RUN, 2 second start during RUN
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit whi, input bit wlo, input logic [31:0] wdv, input int inject);
    int n, lat, busy_err, hold_err;
    bit got_done;
    logic [63:0] r;
    if (whi) exp_hi = wdv;
    if (wlo) exp_lo = wdv;
    start = 1'b1; op = o; a = x; b = y; hi_we = whi; lo_we = wlo; wd = wdv;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    check({tag, "_busy0"}, busy, 1);
    lat = (o[1] && !DIV_ON) ? 2 : 33;
    n = 0; got_done = 0; busy_err = 0; hold_err = 0;
    while (!got_done && n < 50) begin
      if (inject == 1 && n == 5) begin hi_we = 1'b1; wd = 32'hDEAD_BEEF; end
      if (inject == 2 && n == 5) begin start = 1'b1; op = 2'b01; a = 9; b = 9; end
      @(posedge clk); #1;
      n++;
      hi_we = 1'b0; start = 1'b0;
      if (done) got_done = 1;
      else begin
        if (!busy) busy_err++;
        if (hi !== exp_hi || lo !== exp_lo) hold_err++;
      end
    end
    if (!o[1] || DIV_ON) begin
      r = model(o, x, y);
      exp_hi = r[63:32];
      exp_lo = r[31:0];
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_done"}, got_done, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_busy_run"}, busy_err, 0);
    check({tag, "_hold"}, hold_err, 0);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk); #1;
    check({tag, "_nodone"}, done, 0);
  endtask

  initial begin
    int nd;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    reset = 1'b0;
    idle_cycle("rst");

    // Directed ops; MULT then DIVU is a back-to-back start in the done cycle
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);
    check("multu_max_hi_k", hi, 64'hFFFF_FFFE);
    check("multu_max_lo_k", lo, 64'h0000_0001);
    idle_cycle("multu_max");
    run_op("mult_neg", 2'b00, -32'sd3, 32'd5, 0, 0, 0, 0);
    check("mult_neg_hi_k", hi, 64'hFFFF_FFFF);
    check("mult_neg_lo_k", lo, 64'hFFFF_FFF1);
    run_op("divu_b2b", 2'b11, 32'd100, 32'd7, 0, 0, 0, 0);
    idle_cycle("divu_b2b");
    run_op("div_neg", 2'b10, -32'sd7, 32'd2, 0, 0, 0, 0);
    idle_cycle("div_neg");
    run_op("divu_zero", 2'b11, 32'd10, 32'd0, 0, 0, 0, 0);
    idle_cycle("divu_zero");
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 0);
    idle_cycle("div_ovf");

    // MTHI / MTLO in idle
    hi_we = 1'b1; wd = 32'h1234;
    @(posedge clk); #1;
    hi_we = 1'b0; exp_hi = 32'h1234;
    check("mthi", hi, exp_hi);
    lo_we = 1'b1; wd = 32'h5678;
    @(posedge clk); #1;
    lo_we = 1'b0; exp_lo = 32'h5678;
    check("mtlo", lo, exp_lo);
    check("mtlo_hi_kept", hi, 32'h1234);

    // Writes and starts while busy are ignored
    run_op("hiwe_run", 2'b01, 32'd1000, 32'd3000, 0, 0, 0, 1);
    idle_cycle("hiwe_run");
    run_op("start_run", 2'b00, 32'd77, -32'sd11, 0, 0, 0, 2);
    idle_cycle("start_run");

    // Randomized ops, sometimes with an MTHI/MTLO in the start cycle
    for (int i = 0; i < 24; i++) begin
      logic [1:0] ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h8000_0000;
        3: rb = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op($sformatf("rnd%0d", i), ro, ra, rb, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom, 0);
      if ($urandom_range(0, 1) == 1) idle_cycle($sformatf("rnd%0d", i));
    end

    // Reset pulsed mid-operation
    start = 1'b1; op = 2'b01; a = 32'hFFFF_FFFF; b = 32'h1234_5678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    exp_hi = '0; exp_lo = '0;
    check("midrst_busy", busy, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    nd = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    check("midrst_nodone", nd, 0);
    check("midrst_busy_after", busy, 0);
    run_op("multu_6x7", 2'b01, 32'd6, 32'd7, 0, 0, 0, 0);
    check("multu_6x7_lo_k", lo, 42);
    check("multu_6x7_hi_k", hi, 0);
    idle_cycle("multu_6x7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
